// File: rtl/tx_symbol_serializer_if.sv
// rtl/tx_symbol_serializer_if.sv - word handshake between symbol source and serializer
interface tx_symbol_serializer_if #(
    parameter int SYM_WIDTH = 10,
    parameter int MAX_SYMS  = 4
);
    localparam int CNT_W = $clog2(MAX_SYMS + 1);

    logic                          IN_VALID;
    logic                          IN_READY;
    logic [SYM_WIDTH*MAX_SYMS-1:0] IN_DATA;
    logic [CNT_W-1:0]              IN_COUNT;

    modport master (
        output IN_VALID,
        output IN_DATA,
        output IN_COUNT,
        input  IN_READY
    );

    modport slave (
        input  IN_VALID,
        input  IN_DATA,
        input  IN_COUNT,
        output IN_READY
    );
endinterface

// File: rtl/tx_symbol_serializer.sv
// rtl/tx_symbol_serializer.sv - variable-length symbol word to serial bit stream with idle fill
module tx_symbol_serializer #(
    parameter int                   SYM_WIDTH = 10,
    parameter int                   MAX_SYMS  = 4,
    parameter logic [SYM_WIDTH-1:0] IDLE_SYM  = 10'h17C
) (
    input  logic                      CLK,
    input  logic                      RESET_SER,
    input  logic                      ENB,
    tx_symbol_serializer_if.slave     in_if,
    output logic                      OUT_SERIAL,
    output logic                      OUT_SYM_START,
    output logic                      OUT_IDLE,
    output logic                      ERR
);
    localparam int CNT_W  = $clog2(MAX_SYMS + 1);
    localparam int BC_W   = $clog2(SYM_WIDTH);
    localparam int REM_W  = (MAX_SYMS > 1) ? $clog2(MAX_SYMS) : 1;
    localparam int WORD_W = SYM_WIDTH * MAX_SYMS;

    logic [SYM_WIDTH-1:0] sr;
    logic [BC_W-1:0]      bc;
    logic [WORD_W-1:0]    word_buf;
    logic [REM_W-1:0]     rem;

    logic                 boundary;
    logic                 accept;
    logic                 count_ok;

    logic [SYM_WIDTH-1:0] load_sym;
    logic                 load_idle;
    logic [WORD_W-1:0]    word_buf_n;
    logic [REM_W-1:0]     rem_n;

    assign boundary = (bc == BC_W'(SYM_WIDTH - 1));

    // Gating with RESET_SER keeps the source from handing over a word that
    // the reset edge would immediately discard.
    assign in_if.IN_READY = RESET_SER && ENB && boundary && (rem == '0);
    assign accept         = in_if.IN_VALID && in_if.IN_READY;
    assign count_ok       = (in_if.IN_COUNT != '0) &&
                            (in_if.IN_COUNT <= CNT_W'(MAX_SYMS));

    // Buffered symbols always win over a new word, so a word drains fully
    // even after ENB falls; with nothing pending the line is idle-filled.
    always_comb begin
        load_sym   = IDLE_SYM;
        load_idle  = 1'b1;
        word_buf_n = word_buf;
        rem_n      = rem;
        if (boundary) begin
            if (rem != '0) begin
                load_sym   = word_buf[SYM_WIDTH-1:0];
                load_idle  = 1'b0;
                word_buf_n = word_buf >> SYM_WIDTH;
                rem_n      = rem - 1'b1;
            end else if (accept && count_ok) begin
                load_sym   = in_if.IN_DATA[SYM_WIDTH-1:0];
                load_idle  = 1'b0;
                word_buf_n = in_if.IN_DATA >> SYM_WIDTH;
                rem_n      = REM_W'(in_if.IN_COUNT - 1'b1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_SER) begin
            sr            <= '0;
            bc            <= BC_W'(SYM_WIDTH - 1);
            word_buf      <= '0;
            rem           <= '0;
            OUT_SERIAL    <= 1'b0;
            OUT_SYM_START <= 1'b0;
            OUT_IDLE      <= 1'b1;
            ERR           <= 1'b0;
        end else begin
            ERR <= accept && !count_ok;
            if (boundary) begin
                OUT_SERIAL    <= load_sym[0];
                sr            <= load_sym >> 1;
                bc            <= '0;
                OUT_SYM_START <= 1'b1;
                OUT_IDLE      <= load_idle;
                word_buf      <= word_buf_n;
                rem           <= rem_n;
            end else begin
                OUT_SERIAL    <= sr[0];
                sr            <= sr >> 1;
                bc            <= bc + 1'b1;
                OUT_SYM_START <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tx_symbol_serializer.sv
// tb/tb_tx_symbol_serializer.sv - scoreboard bench for tx_symbol_serializer
module tb_tx_symbol_serializer;
    localparam int SW = 10;
    localparam int MS = 4;
    localparam logic [SW-1:0] IDLE = 10'h17C;

    logic CLK = 1'b0;
    logic RESET_SER;
    logic ENB;
    logic OUT_SERIAL, OUT_SYM_START, OUT_IDLE, ERR;

    tx_symbol_serializer_if #(.SYM_WIDTH(SW), .MAX_SYMS(MS)) bus ();

    tx_symbol_serializer #(.SYM_WIDTH(SW), .MAX_SYMS(MS), .IDLE_SYM(IDLE)) dut (
        .CLK           (CLK),
        .RESET_SER     (RESET_SER),
        .ENB           (ENB),
        .in_if         (bus.slave),
        .OUT_SERIAL    (OUT_SERIAL),
        .OUT_SYM_START (OUT_SYM_START),
        .OUT_IDLE      (OUT_IDLE),
        .ERR           (ERR)
    );

    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;

    logic [SW-1:0] exp_q[$];
    logic          err_pending = 1'b0;
    logic          rst_edge    = 1'b1;
    logic          started     = 1'b0;
    int            mbc         = SW - 1;
    logic [SW-1:0] cur         = IDLE;
    logic          cur_idle    = 1'b1;
    logic          exp_start;

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    endtask

    always @(posedge CLK) begin
        rst_edge <= !RESET_SER;
        started  <= 1'b1;
    end

    // Monitor: the line never stalls, so every cycle is an output to check.
    always @(negedge CLK) begin
        if (started) begin
            if (rst_edge) begin
                exp_q.delete();
                mbc         = SW - 1;
                cur         = IDLE;
                cur_idle    = 1'b1;
                err_pending = 1'b0;
                chk("rst_serial", OUT_SERIAL, 1'b0);
                chk("rst_start", OUT_SYM_START, 1'b0);
                chk("rst_idle", OUT_IDLE, 1'b1);
                chk("rst_err", ERR, 1'b0);
            end else begin
                if (mbc == SW - 1) begin
                    mbc       = 0;
                    exp_start = 1'b1;
                    if (exp_q.size() > 0) begin
                        cur      = exp_q.pop_front();
                        cur_idle = 1'b0;
                    end else begin
                        cur      = IDLE;
                        cur_idle = 1'b1;
                    end
                end else begin
                    mbc++;
                    exp_start = 1'b0;
                end
                chk("serial", OUT_SERIAL, cur[mbc]);
                chk("sym_start", OUT_SYM_START, exp_start);
                chk("idle", OUT_IDLE, cur_idle);
                chk("err", ERR, err_pending);
                err_pending = 1'b0;
            end
            chk("in_ready", bus.IN_READY,
                RESET_SER && ENB && (mbc == SW - 1) && (exp_q.size() == 0));
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_word(input logic [SW*MS-1:0] d, input logic [2:0] c);
        int  n    = 0;
        bit  done = 1'b0;
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = d;
        bus.IN_COUNT = c;
        while (!done && n < 200) begin
            @(negedge CLK);
            #1;
            if (bus.IN_READY) begin
                done = 1'b1;
                if (c >= 1 && c <= MS) begin
                    for (int i = 0; i < int'(c); i++) exp_q.push_back(d[i*SW +: SW]);
                end else begin
                    err_pending = 1'b1;
                end
            end
            step();
            n++;
        end
        bus.IN_VALID = 1'b0;
        if (!done) begin
            total++;
            $display("FAIL accept_timeout: no IN_READY within %0d cycles, required acceptance", n);
        end
    endtask

    localparam logic [SW*MS-1:0] FULL = {10'h3FF, 10'h000, 10'h155, 10'h2AA};

    initial begin
        RESET_SER    = 1'b0;
        ENB          = 1'b1;
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = FULL;
        bus.IN_COUNT = 3'd4;
        repeat (3) step();
        RESET_SER    = 1'b1;
        bus.IN_VALID = 1'b0;
        repeat (30) step();

        send_word(FULL, 3'd4);
        repeat (45) step();

        send_word({30'h0, 10'h2AA}, 3'd1);
        send_word({30'h0, 10'h155}, 3'd1);
        repeat (15) step();

        send_word(FULL, 3'd0);
        send_word(FULL, 3'd5);
        repeat (15) step();

        send_word(FULL, 3'd4);
        repeat (14) step();
        ENB = 1'b0;
        repeat (40) step();
        ENB = 1'b1;
        repeat (5) step();

        send_word(FULL, 3'd4);
        repeat (14) step();
        RESET_SER = 1'b0;
        repeat (2) step();
        RESET_SER = 1'b1;
        repeat (25) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end
endmodule
